// File: rtl/qmca_clk_seq.sv
// Power-up / re-lock sequencer for the two-stage DCM chain; lock inputs pass 2-FF synchronisers, outputs registered from next state.
// Optional lock-loss counter enabled by defining QMCA_CLK_SEQ_LOSS_CNT_EN (otherwise LOSS_CNT reads 0).
module qmca_clk_seq #(
  parameter int RST_PULSE    = 4,
  parameter int LOCK_TIMEOUT = 48000,
  parameter int SETTLE       = 256,
  parameter int MAX_RETRY    = 3
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        LOCKED_U1,
  input  logic        LOCKED_U2,
  input  logic        RESTART,
  output logic        DCM2_RST,
  output logic        ADC_RST,
  output logic        READY,
  output logic        ERROR,
  output logic [2:0]  STATE,
  output logic [2:0]  RETRY_CNT,
  output logic [15:0] LOSS_CNT
);

  localparam int MAX_AB = (LOCK_TIMEOUT > SETTLE) ? LOCK_TIMEOUT : SETTLE;
  localparam int MAX_T  = (MAX_AB > RST_PULSE) ? MAX_AB : RST_PULSE;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0] T_RST    = TW'(RST_PULSE - 1);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_WAIT_U1 = 3'd0,
    S_RST_U2  = 3'd1,
    S_WAIT_U2 = 3'd2,
    S_SETTLE  = 3'd3,
    S_RUN     = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    retry, retry_n, retry_inc;
  logic [1:0]    l1_sync, l2_sync;
  logic          l1, l2;

  assign l1        = l1_sync[1];
  assign l2        = l2_sync[1];
  assign retry_inc = retry + 3'd1;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      l1_sync <= 2'b00;
      l2_sync <= 2'b00;
    end else begin
      l1_sync <= {l1_sync[0], LOCKED_U1};
      l2_sync <= {l2_sync[0], LOCKED_U2};
    end
  end

  always_comb begin
    state_n = state;
    timer_n = (timer != '0) ? timer - TW'(1) : '0;
    retry_n = retry;
    if (RESTART) begin
      state_n = S_WAIT_U1;
      retry_n = 3'd0;
    end else if (!l1 && state != S_WAIT_U1 && state != S_FAIL) begin
      state_n = S_WAIT_U1;
    end else begin
      case (state)
        S_WAIT_U1: if (l1) begin
          state_n = S_RST_U2;
          timer_n = T_RST;
        end
        S_RST_U2: if (timer == '0) begin
          state_n = S_WAIT_U2;
          timer_n = T_LOCK;
        end
        S_WAIT_U2: begin
          // Lock wins over a coincident timeout.
          if (l2) begin
            state_n = S_SETTLE;
            timer_n = T_SETTLE;
          end else if (timer == '0) begin
            retry_n = retry_inc;
            state_n = (retry_inc == RETRY_MAX) ? S_FAIL : S_RST_U2;
            timer_n = T_RST;
          end
        end
        S_SETTLE: begin
          if (!l2) begin
            retry_n = retry_inc;
            state_n = (retry_inc == RETRY_MAX) ? S_FAIL : S_RST_U2;
            timer_n = T_RST;
          end else if (timer == '0) begin
            state_n = S_RUN;
            retry_n = 3'd0;
          end
        end
        S_RUN: if (!l2) begin
          state_n = S_RST_U2;
          timer_n = T_RST;
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state    <= S_WAIT_U1;
      timer    <= '0;
      retry    <= 3'd0;
      DCM2_RST <= 1'b1;
      ADC_RST  <= 1'b1;
      READY    <= 1'b0;
      ERROR    <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      retry    <= retry_n;
      DCM2_RST <= (state_n == S_WAIT_U1) || (state_n == S_RST_U2) || (state_n == S_FAIL);
      ADC_RST  <= (state_n != S_RUN);
      READY    <= (state_n == S_RUN);
      ERROR    <= (state_n == S_FAIL);
    end
  end

  assign STATE     = state;
  assign RETRY_CNT = retry;

`ifdef QMCA_CLK_SEQ_LOSS_CNT_EN
  logic        loss_evt;
  logic [15:0] loss_cnt;

  // Any lock loss leaving RUN counts; RESTART takes priority and is not a loss.
  assign loss_evt = (state == S_RUN) && !RESTART && !(l1 && l2);

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST)
      loss_cnt <= 16'h0000;
    else if (loss_evt && loss_cnt != 16'hFFFF)
      loss_cnt <= loss_cnt + 16'd1;
  end

  assign LOSS_CNT = loss_cnt;
`else
  assign LOSS_CNT = 16'h0000;
`endif

endmodule
